// File: rtl/nv_nvdla_sdp_brdma_pkg.sv
// Shared constants and response layout for the BRDMA egress path.
// A response carries two 256-bit atoms plus a mask saying which halves are live.
package nv_nvdla_sdp_brdma_pkg;

   localparam int DATA_W   = 512;
   localparam int MASK_W   = 2;
   localparam int RSP_W    = DATA_W + MASK_W;
   localparam int ATOM_W   = DATA_W / 2;
   localparam int CNT_W    = 14;
   localparam int MASK_LSB = DATA_W;

   typedef struct packed {
      logic [MASK_W-1:0] mask;
      logic [DATA_W-1:0] data;
   } rsp_pd_t;

   // Drops the lowest set bit, i.e. retires the atom just emitted.
   function automatic logic [MASK_W-1:0] clear_lowest(input logic [MASK_W-1:0] m);
      return m & (m - MASK_W'(1));
   endfunction

endpackage

// File: rtl/nv_nvdla_sdp_brdma_eg_unpack_if.sv
// Response-in / atom-out handshake bundle for the BRDMA egress unpacker.
// slave is the unpacker's view; master is the side driving responses and taking atoms.
interface nv_nvdla_sdp_brdma_eg_unpack_if;
   import nv_nvdla_sdp_brdma_pkg::*;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [RSP_W-1:0]  rsp_pd;
   logic              atom_valid;
   logic              atom_ready;
   logic [ATOM_W-1:0] atom_pd;

   modport slave (
      input  rsp_valid, rsp_pd, atom_ready,
      output rsp_ready, atom_valid, atom_pd
   );

   modport master (
      output rsp_valid, rsp_pd, atom_ready,
      input  rsp_ready, atom_valid, atom_pd
   );

endinterface

// File: rtl/nv_nvdla_sdp_brdma_eg_unpack.sv
// Splits 512-bit DMA read responses into 256-bit atoms (mask[0] half first)
// and counts emitted atoms against the layer size to pulse layer_done.
module nv_nvdla_sdp_brdma_eg_unpack
   import nv_nvdla_sdp_brdma_pkg::*;
(
   input  logic                                nvdla_core_clk,
   input  logic                                nvdla_core_rstn,
   input  logic                                op_en,
   input  logic [CNT_W-1:0]                    cfg_atom_num,
   nv_nvdla_sdp_brdma_eg_unpack_if.slave       io,
   output logic                                layer_done,
   output logic                                err_mask_zero
);

   rsp_pd_t           rsp;
   logic              hold_vld;
   logic [MASK_W-1:0] hold_mask;
   logic [DATA_W-1:0] hold_data;
   logic [CNT_W-1:0]  atom_cnt;
   logic [CNT_W-1:0]  cnt_last;
   logic              rst_done;
   logic              last_atom;
   logic              atom_acc;
   logic              rsp_acc;
   logic              rsp_load;

   assign rsp = io.rsp_pd;

   assign last_atom = hold_vld && ((hold_mask == 2'b01) || (hold_mask == 2'b10));
   assign atom_acc  = hold_vld && io.atom_ready;

   // rst_done keeps rsp_ready low while reset is asserted and for the first cycle after.
   assign io.rsp_ready = rst_done && op_en && (!hold_vld || (last_atom && io.atom_ready));
   assign rsp_acc      = io.rsp_valid && io.rsp_ready;
   assign rsp_load     = rsp_acc && (rsp.mask != '0);

   assign io.atom_valid = hold_vld;
   assign io.atom_pd    = hold_mask[0] ? hold_data[ATOM_W-1:0] : hold_data[DATA_W-1:ATOM_W];

   assign cnt_last = cfg_atom_num - CNT_W'(1);

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         rst_done      <= 1'b0;
         hold_vld      <= 1'b0;
         hold_mask     <= '0;
         err_mask_zero <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         if (rsp_load) begin
            hold_vld  <= 1'b1;
            hold_mask <= rsp.mask;
         end else if (atom_acc) begin
            hold_mask <= clear_lowest(hold_mask);
            hold_vld  <= (clear_lowest(hold_mask) != '0);
         end
         if (rsp_acc && (rsp.mask == '0)) begin
            err_mask_zero <= 1'b1;
         end
      end
   end

   // NOTE: payload flops carry no reset; hold_vld/hold_mask qualify them.
   always_ff @(posedge nvdla_core_clk) begin
      if (rsp_load) begin
         hold_data <= rsp.data;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         atom_cnt   <= '0;
         layer_done <= 1'b0;
      end else if (!op_en) begin
         // Atoms drained while disabled are not part of any layer.
         atom_cnt   <= '0;
         layer_done <= 1'b0;
      end else if (atom_acc) begin
         if (atom_cnt == cnt_last) begin
            atom_cnt   <= '0;
            layer_done <= 1'b1;
         end else begin
            atom_cnt   <= atom_cnt + CNT_W'(1);
            layer_done <= 1'b0;
         end
      end else begin
         layer_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nv_nvdla_sdp_brdma_eg_unpack.sv
// Scoreboard bench for the BRDMA egress unpacker: stimulus queues expected atoms,
// a negedge monitor pops and compares every accepted atom and logs layer_done.
module tb_nv_nvdla_sdp_brdma_eg_unpack;
   import nv_nvdla_sdp_brdma_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             op_en = 1'b0;
   logic [CNT_W-1:0] cfg_atom_num = CNT_W'(4);
   logic             layer_done;
   logic             err_mask_zero;

   nv_nvdla_sdp_brdma_eg_unpack_if dma();

   nv_nvdla_sdp_brdma_eg_unpack dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rst_n),
      .op_en           (op_en),
      .cfg_atom_num    (cfg_atom_num),
      .io              (dma),
      .layer_done      (layer_done),
      .err_mask_zero   (err_mask_zero)
   );

   always #5 clk = ~clk;

   int                n_checks = 0;
   int                n_errors = 0;
   int                cyc = 0;
   logic [ATOM_W-1:0] exp_q[$];
   int                acc_log[$];
   int                ld_log[$];

   task automatic check_pd(input string name, input logic [ATOM_W-1:0] act, input logic [ATOM_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [ATOM_W-1:0] atom_val(input logic [31:0] tag);
      return {8{tag}};
   endfunction

   // Monitor: one sample per cycle, mid-cycle, well away from the rising edge.
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (dma.atom_valid && dma.atom_ready) begin
            acc_log.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL atom_unexpected: got %h expected no atom", dma.atom_pd);
            end else begin
               check_pd("atom_pd", dma.atom_pd, exp_q.pop_front());
            end
         end
         if (layer_done) ld_log.push_back(cyc);
      end
   end

   always @(posedge clk) begin
      if (rst_n && op_en) assert (cfg_atom_num != '0) else $error("cfg_atom_num is zero");
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   // Presents one response and returns at posedge+2 right after its handshake.
   task automatic send_rsp(input logic [1:0] mask, input logic [ATOM_W-1:0] lo,
                           input logic [ATOM_W-1:0] hi, input bit push, output int waited);
      waited = 0;
      dma.rsp_valid = 1'b1;
      dma.rsp_pd    = {mask, hi, lo};
      if (push) begin
         if (mask[0]) exp_q.push_back(lo);
         if (mask[1]) exp_q.push_back(hi);
      end
      @(negedge clk);
      while (!dma.rsp_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!dma.rsp_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL rsp_timeout: rsp_ready low for %0d cycles, required 1", waited);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic idle_rsp();
      dma.rsp_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int w;
      int w2;
      dma.rsp_valid  = 1'b0;
      dma.rsp_pd     = '0;
      dma.atom_ready = 1'b1;

      // Reset state
      #1;
      check("rst_atom_valid", int'(dma.atom_valid), 0);
      check("rst_rsp_ready", int'(dma.rsp_ready), 0);
      check("rst_layer_done", int'(layer_done), 0);
      check("rst_err_mask_zero", int'(err_mask_zero), 0);
      cycles(2);
      rst_n = 1'b1;
      op_en = 1'b1;
      cfg_atom_num = CNT_W'(4);
      cycles(1);

      // T1: two mask=11 responses, layer of 4
      send_rsp(2'b11, atom_val(32'hA000_0000), atom_val(32'hA000_0001), 1'b1, w);
      check("t1_rsp_a_wait", w, 0);
      send_rsp(2'b11, atom_val(32'hB000_0000), atom_val(32'hB000_0001), 1'b1, w);
      check("t1_rsp_b_wait", w, 1);
      idle_rsp();
      @(negedge clk);
      check("t1_rsp_ready_after_b", int'(dma.rsp_ready), 0);
      cycles(4);
      check("t1_atom_count", acc_log.size(), 4);
      check("t1_ld_count", ld_log.size(), 1);
      if (acc_log.size() >= 4 && ld_log.size() >= 1) begin
         check("t1_atoms_back_to_back", acc_log[3] - acc_log[0], 3);
         check("t1_ld_after_b1", ld_log[0], acc_log[3] + 1);
      end

      // T2: single-atom responses streamed back to back
      send_rsp(2'b01, atom_val(32'hC100_0000), atom_val(32'hC1FF_FFFF), 1'b1, w);
      send_rsp(2'b10, atom_val(32'hC2FF_FFFF), atom_val(32'hC200_0001), 1'b1, w2);
      check("t2_wait_1", w2, 0);
      send_rsp(2'b01, atom_val(32'hC300_0000), atom_val(32'hC3FF_FFFF), 1'b1, w2);
      check("t2_wait_2", w2, 0);
      send_rsp(2'b10, atom_val(32'hC4FF_FFFF), atom_val(32'hC400_0001), 1'b1, w2);
      check("t2_wait_3", w2, 0);
      idle_rsp();
      cycles(4);
      check("t2_atom_count", acc_log.size(), 8);
      check("t2_ld_count", ld_log.size(), 2);
      if (acc_log.size() >= 8 && ld_log.size() >= 2) begin
         check("t2_no_bubbles", acc_log[7] - acc_log[4], 3);
         check("t2_ld_after_last", ld_log[1], acc_log[7] + 1);
      end

      // T3: downstream stalls for 5 cycles on a mask=11 response
      dma.atom_ready = 1'b0;
      send_rsp(2'b11, atom_val(32'hD000_0000), atom_val(32'hD000_0001), 1'b1, w);
      idle_rsp();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3_stall_valid", int'(dma.atom_valid), 1);
         check_pd("t3_stall_pd", dma.atom_pd, atom_val(32'hD000_0000));
         check("t3_stall_rsp_ready", int'(dma.rsp_ready), 0);
      end
      @(posedge clk);
      #2;
      check("t3_stall_no_accept", acc_log.size(), 8);
      dma.atom_ready = 1'b1;
      cycles(4);
      check("t3_atom_count", acc_log.size(), 10);
      check("t3_ld_count", ld_log.size(), 2);

      // T5: op_en dropped mid-layer (2 of 4), then a fresh 3-atom layer
      op_en = 1'b0;
      dma.rsp_valid = 1'b1;
      @(negedge clk);
      check("t5_ready_when_off", int'(dma.rsp_ready), 0);
      idle_rsp();
      cycles(3);
      check("t5_no_ld_at_drop", ld_log.size(), 2);
      cfg_atom_num = CNT_W'(3);
      op_en = 1'b1;
      send_rsp(2'b01, atom_val(32'hE100_0000), atom_val(32'hE1FF_FFFF), 1'b1, w);
      send_rsp(2'b10, atom_val(32'hE2FF_FFFF), atom_val(32'hE200_0001), 1'b1, w);
      send_rsp(2'b01, atom_val(32'hE300_0000), atom_val(32'hE3FF_FFFF), 1'b1, w);
      idle_rsp();
      cycles(4);
      check("t5_atom_count", acc_log.size(), 13);
      check("t5_ld_count", ld_log.size(), 3);
      if (acc_log.size() >= 13 && ld_log.size() >= 3) begin
         check("t5_ld_after_third", ld_log[2], acc_log[12] + 1);
      end

      // T4: zero-mask response sets the sticky error and emits nothing
      check("t4_err_before", int'(err_mask_zero), 0);
      send_rsp(2'b00, atom_val(32'h5A5A_5A5A), atom_val(32'hA5A5_A5A5), 1'b1, w);
      check("t4_zero_mask_wait", w, 0);
      idle_rsp();
      @(negedge clk);
      check("t4_err_set", int'(err_mask_zero), 1);
      check("t4_no_atom_valid", int'(dma.atom_valid), 0);
      cycles(5);
      check("t4_err_sticky", int'(err_mask_zero), 1);
      check("t4_atom_count", acc_log.size(), 13);

      // T6: reset while a mask=11 response is held and stalled
      dma.atom_ready = 1'b0;
      send_rsp(2'b11, atom_val(32'hF000_0000), atom_val(32'hF000_0001), 1'b0, w);
      @(negedge clk);
      check("t6_held_valid", int'(dma.atom_valid), 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      idle_rsp();
      #1;
      check("t6_rst_atom_valid", int'(dma.atom_valid), 0);
      check("t6_rst_rsp_ready", int'(dma.rsp_ready), 0);
      check("t6_rst_layer_done", int'(layer_done), 0);
      check("t6_rst_err_clear", int'(err_mask_zero), 0);
      cycles(2);
      rst_n = 1'b1;
      dma.atom_ready = 1'b1;
      cfg_atom_num = CNT_W'(2);
      cycles(2);
      send_rsp(2'b11, atom_val(32'h1234_0000), atom_val(32'h1234_0001), 1'b1, w);
      idle_rsp();
      cycles(5);
      check("t6_atom_count", acc_log.size(), 15);
      check("t6_ld_count", ld_log.size(), 4);
      if (acc_log.size() >= 15 && ld_log.size() >= 4) begin
         check("t6_ld_after_second", ld_log[3], acc_log[14] + 1);
      end
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
